// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the MIPS32 execute stage.
// The stage is the slave; the upstream/downstream environment is the master.
interface ex_stage_if;
    logic [31:0] in_pc4;
    logic [31:0] in_d1;
    logic [31:0] in_d2;
    logic [31:0] in_imm;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        in_reg_dst;
    logic        in_branch;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_alu_src;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic        in_jump;
    logic [2:0]  in_alu_op;
    logic [31:0] in_jump_target;

    logic        stall;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_dest;
    logic        out_branch_taken;
    logic [31:0] out_branch_target;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_reg_write;
    logic        out_mem_to_reg;
    logic        out_jump;
    logic [31:0] out_jump_target;

    modport slave (
        input  in_pc4, in_d1, in_d2, in_imm, in_rt, in_rd, in_reg_dst, in_branch,
               in_mem_read, in_mem_write, in_alu_src, in_reg_write, in_mem_to_reg,
               in_jump, in_alu_op, in_jump_target,
        output stall, out_alu_result, out_store_data, out_dest, out_branch_taken,
               out_branch_target, out_mem_read, out_mem_write, out_reg_write,
               out_mem_to_reg, out_jump, out_jump_target
    );

    modport master (
        output in_pc4, in_d1, in_d2, in_imm, in_rt, in_rd, in_reg_dst, in_branch,
               in_mem_read, in_mem_write, in_alu_src, in_reg_write, in_mem_to_reg,
               in_jump, in_alu_op, in_jump_target,
        input  stall, out_alu_result, out_store_data, out_dest, out_branch_taken,
               out_branch_target, out_mem_read, out_mem_write, out_reg_write,
               out_mem_to_reg, out_jump, out_jump_target
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS32 execute stage: ALU, branch compare/target, destination select and an
// iterative shift-add multiplier that stalls upstream while it runs.
module ex_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    ex_stage_if.slave  bus
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  dest;
        logic        branch_taken;
        logic [31:0] branch_target;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        jump;
        logic [31:0] jump_target;
    } exmem_t;

    state_t          state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]     acc, mcand, mplier;
    logic [31:0]     op_b, alu_res;
    logic [5:0]      funct;
    logic            zero, is_mul, mul_start;
    exmem_t          exmem_d, exmem_q;

    assign op_b      = bus.in_alu_src ? bus.in_imm : bus.in_d2;
    assign funct     = bus.in_imm[5:0];
    assign zero      = (bus.in_d1 == bus.in_d2);
    assign is_mul    = (bus.in_alu_op == 3'b010) && (funct == 6'b011000);
    assign mul_start = (state == ST_IDLE) && is_mul && !flush;
    assign bus.stall = mul_start || (state == ST_MUL);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        case (bus.in_alu_op)
            3'b001: alu_res = bus.in_d1 - op_b;
            3'b010: begin
                case (funct)
                    6'b100000: alu_res = bus.in_d1 + op_b;
                    6'b100010: alu_res = bus.in_d1 - op_b;
                    6'b100100: alu_res = bus.in_d1 & op_b;
                    6'b100101: alu_res = bus.in_d1 | op_b;
                    6'b101010: alu_res = {31'b0, $signed(bus.in_d1) < $signed(op_b)};
                    default:   alu_res = '0;
                endcase
            end
            3'b011: alu_res = bus.in_d1 & op_b;
            3'b100: alu_res = bus.in_d1 | op_b;
            3'b101: alu_res = {31'b0, $signed(bus.in_d1) < $signed(op_b)};
            default: alu_res = bus.in_d1 + op_b;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (cnt == LAST_CNT) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (mul_start) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= bus.in_d1;
            mplier <= bus.in_d2;
        end else if (state == ST_MUL) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // A stalled or flushed edge loads a bubble; DONE retires the product.
    always_comb begin
        exmem_d = '0;
        if (!(flush || bus.stall)) begin
            exmem_d.alu_result    = (state == ST_DONE) ? acc : alu_res;
            exmem_d.store_data    = bus.in_d2;
            exmem_d.dest          = bus.in_reg_dst ? bus.in_rd : bus.in_rt;
            exmem_d.branch_taken  = bus.in_branch && zero;
            exmem_d.branch_target = bus.in_pc4 + {bus.in_imm[29:0], 2'b00};
            exmem_d.mem_read      = bus.in_mem_read;
            exmem_d.mem_write     = bus.in_mem_write;
            exmem_d.reg_write     = bus.in_reg_write;
            exmem_d.mem_to_reg    = bus.in_mem_to_reg;
            exmem_d.jump          = bus.in_jump;
            exmem_d.jump_target   = bus.in_jump_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) exmem_q <= '0;
        else        exmem_q <= exmem_d;
    end

    assign bus.out_alu_result    = exmem_q.alu_result;
    assign bus.out_store_data    = exmem_q.store_data;
    assign bus.out_dest          = exmem_q.dest;
    assign bus.out_branch_taken  = exmem_q.branch_taken;
    assign bus.out_branch_target = exmem_q.branch_target;
    assign bus.out_mem_read      = exmem_q.mem_read;
    assign bus.out_mem_write     = exmem_q.mem_write;
    assign bus.out_reg_write     = exmem_q.reg_write;
    assign bus.out_mem_to_reg    = exmem_q.mem_to_reg;
    assign bus.out_jump          = exmem_q.jump;
    assign bus.out_jump_target   = exmem_q.jump_target;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table plus multiply, flush and
// reset-abort sequences, all checked through an expected-result queue.
module tb_ex_stage;
    typedef struct {
        logic [31:0] pc4, d1, d2, imm, jt;
        logic [4:0]  rt, rd;
        logic        reg_dst, branch, mem_read, mem_write, alu_src, reg_write, mem_to_reg, jump;
        logic [2:0]  alu_op;
    } in_t;

    typedef struct {
        logic [31:0] alu, store, target, jt;
        logic [4:0]  dest;
        logic        taken, mr, mw, rw, m2r, j;
    } exp_t;

    typedef struct {
        string name;
        in_t   i;
        exp_t  e;
    } vec_t;

    logic clk, rst_n, flush;
    int   n_cmp, n_err;
    exp_t sb[$];
    vec_t vecs[$];

    ex_stage_if bus();
    ex_stage #(.MUL_CYCLES(32)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(input logic [2:0] op, input logic [31:0] d1, d2, imm,
                                  input logic alu_src, reg_dst, input logic [4:0] rt, rd,
                                  input logic [31:0] pc4, input logic branch,
                                  input logic [3:0] ctl, input logic jump, input logic [31:0] jt);
        in_t v;
        v.alu_op = op; v.d1 = d1; v.d2 = d2; v.imm = imm;
        v.alu_src = alu_src; v.reg_dst = reg_dst; v.rt = rt; v.rd = rd;
        v.pc4 = pc4; v.branch = branch;
        {v.reg_write, v.mem_read, v.mem_write, v.mem_to_reg} = ctl;
        v.jump = jump; v.jt = jt;
        return v;
    endfunction

    function automatic exp_t mk_exp(input in_t v, input logic [31:0] alu,
                                    input logic [4:0] dest, input logic taken);
        exp_t e;
        e.alu = alu; e.dest = dest; e.taken = taken;
        e.store = v.d2; e.target = v.pc4 + (v.imm << 2); e.jt = v.jt;
        e.mr = v.mem_read; e.mw = v.mem_write; e.rw = v.reg_write;
        e.m2r = v.mem_to_reg; e.j = v.jump;
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.alu = '0; e.store = '0; e.target = '0; e.jt = '0; e.dest = '0;
        e.taken = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.rw = 1'b0; e.m2r = 1'b0; e.j = 1'b0;
        return e;
    endfunction

    function automatic in_t nop_in();
        return mk_in(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    task automatic drive(input in_t v);
        bus.in_pc4 = v.pc4; bus.in_d1 = v.d1; bus.in_d2 = v.d2; bus.in_imm = v.imm;
        bus.in_rt = v.rt; bus.in_rd = v.rd; bus.in_reg_dst = v.reg_dst;
        bus.in_branch = v.branch; bus.in_mem_read = v.mem_read; bus.in_mem_write = v.mem_write;
        bus.in_alu_src = v.alu_src; bus.in_reg_write = v.reg_write;
        bus.in_mem_to_reg = v.mem_to_reg; bus.in_jump = v.jump;
        bus.in_alu_op = v.alu_op; bus.in_jump_target = v.jt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_compare(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty, nothing expected", nm);
            return;
        end
        e = sb.pop_front();
        check({nm, ".alu_result"},    bus.out_alu_result,    e.alu);
        check({nm, ".store_data"},    bus.out_store_data,    e.store);
        check({nm, ".dest"},          32'(bus.out_dest),     32'(e.dest));
        check({nm, ".branch_taken"},  32'(bus.out_branch_taken), 32'(e.taken));
        check({nm, ".branch_target"}, bus.out_branch_target, e.target);
        check({nm, ".mem_read"},      32'(bus.out_mem_read), 32'(e.mr));
        check({nm, ".mem_write"},     32'(bus.out_mem_write), 32'(e.mw));
        check({nm, ".reg_write"},     32'(bus.out_reg_write), 32'(e.rw));
        check({nm, ".mem_to_reg"},    32'(bus.out_mem_to_reg), 32'(e.m2r));
        check({nm, ".jump"},          32'(bus.out_jump),     32'(e.j));
        check({nm, ".jump_target"},   bus.out_jump_target,   e.jt);
    endtask

    // Presents a mul, measures the stall window, then checks the retired product.
    task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] prod);
        in_t m;
        int  stalls, bad;
        m = mk_in(3'b010, a, b, 32'h18, 0, 1, 5'd1, 5'd7, 32'h40, 0, 4'b1000, 0, 32'h0);
        drive(m);
        #1;
        check({nm, ".stall_at_start"}, 32'(bus.stall), 32'd1);
        stalls = 0;
        bad = 0;
        while (bus.stall === 1'b1 && stalls < 40) begin
            stalls++;
            step();
            if (bus.out_reg_write !== 1'b0) bad++;
        end
        check({nm, ".stall_cycles"}, 32'(stalls), 32'd33);
        check({nm, ".reg_write_during_stall"}, 32'(bad), 32'd0);
        sb.push_back(mk_exp(m, prod, 5'd7, 1'b0));
        step();
        pop_compare(nm);
        drive(nop_in());
    endtask

    initial begin
        in_t m;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush = 1'b0;

        vecs.push_back('{"add",   mk_in(3'b010, 7, 5, 32'h20, 0, 1, 4, 3, 32'h10, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"sub",   mk_in(3'b010, 0, 1, 32'h22, 0, 1, 4, 5, 32'h14, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"beq_t", mk_in(3'b001, 32'h1234, 32'h1234, 32'hFFFFFFFE, 0, 0, 2, 3, 32'h100, 1, 4'b0000, 0, 0), '{default: '0}});
        vecs.push_back('{"beq_n", mk_in(3'b001, 32'h1234, 32'h1235, 32'hFFFFFFFE, 0, 0, 2, 3, 32'h100, 1, 4'b0000, 0, 0), '{default: '0}});
        vecs.push_back('{"lw",    mk_in(3'b000, 32'h1000, 32'hDEAD, 32'hFFFFFFFC, 1, 0, 9, 3, 32'h200, 0, 4'b1101, 0, 0), '{default: '0}});
        vecs.push_back('{"sw",    mk_in(3'b000, 32'h2000, 32'hCAFEBABE, 32'h8, 1, 0, 6, 0, 32'h300, 0, 4'b0010, 0, 0), '{default: '0}});
        vecs.push_back('{"and_op", mk_in(3'b011, 32'hF0F01234, 32'h0FF0FFFF, 0, 0, 1, 1, 2, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"ori",   mk_in(3'b100, 32'h1200, 32'h5555, 32'hFF, 1, 0, 8, 0, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"slt_1", mk_in(3'b101, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 10, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"slt_0", mk_in(3'b101, 5, 32'hFFFFFFFE, 0, 0, 1, 0, 11, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"r_and", mk_in(3'b010, 32'hFF00FF00, 32'h0F0F0F0F, 32'h24, 0, 1, 0, 12, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"r_or",  mk_in(3'b010, 32'hA0, 32'h0B, 32'h25, 0, 1, 0, 13, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"r_slt", mk_in(3'b010, 32'h80000000, 0, 32'h2A, 0, 1, 0, 14, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"r_unk", mk_in(3'b010, 3, 4, 32'h0, 0, 1, 0, 15, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"op110", mk_in(3'b110, 32'h7FFFFFFF, 1, 0, 0, 1, 0, 16, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"op111", mk_in(3'b111, 32'hFFFFFFFF, 9, 1, 1, 1, 0, 17, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs.push_back('{"jump",  mk_in(3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 4'b0000, 1, 32'h00400000), '{default: '0}});
        vecs.push_back('{"r_addw", mk_in(3'b010, 32'hFFFFFFFF, 2, 32'h20, 0, 1, 0, 18, 0, 0, 4'b1000, 0, 0), '{default: '0}});
        vecs[0].e  = mk_exp(vecs[0].i,  32'd12,        5'd3,  1'b0);
        vecs[1].e  = mk_exp(vecs[1].i,  32'hFFFFFFFF,  5'd5,  1'b0);
        vecs[2].e  = mk_exp(vecs[2].i,  32'h0,         5'd2,  1'b1);
        vecs[3].e  = mk_exp(vecs[3].i,  32'hFFFFFFFF,  5'd2,  1'b0);
        vecs[4].e  = mk_exp(vecs[4].i,  32'hFFC,       5'd9,  1'b0);
        vecs[5].e  = mk_exp(vecs[5].i,  32'h2008,      5'd6,  1'b0);
        vecs[6].e  = mk_exp(vecs[6].i,  32'h00F01234,  5'd2,  1'b0);
        vecs[7].e  = mk_exp(vecs[7].i,  32'h12FF,      5'd8,  1'b0);
        vecs[8].e  = mk_exp(vecs[8].i,  32'd1,         5'd10, 1'b0);
        vecs[9].e  = mk_exp(vecs[9].i,  32'd0,         5'd11, 1'b0);
        vecs[10].e = mk_exp(vecs[10].i, 32'h0F000F00,  5'd12, 1'b0);
        vecs[11].e = mk_exp(vecs[11].i, 32'hAB,        5'd13, 1'b0);
        vecs[12].e = mk_exp(vecs[12].i, 32'd1,         5'd14, 1'b0);
        vecs[13].e = mk_exp(vecs[13].i, 32'd0,         5'd15, 1'b0);
        vecs[14].e = mk_exp(vecs[14].i, 32'h80000000,  5'd16, 1'b0);
        vecs[15].e = mk_exp(vecs[15].i, 32'd0,         5'd17, 1'b0);
        vecs[16].e = mk_exp(vecs[16].i, 32'd0,         5'd0,  1'b0);
        vecs[17].e = mk_exp(vecs[17].i, 32'd1,         5'd18, 1'b0);

        // Reset with random non-mul inputs.
        m = mk_in(3'($urandom_range(7)), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
                  5'($urandom), 5'($urandom), $urandom, 1'($urandom), 4'($urandom), 1'($urandom), $urandom);
        if (m.alu_op == 3'b010 && m.imm[5:0] == 6'b011000) m.alu_op = 3'b000;
        drive(m);
        step();
        step();
        sb.push_back(bubble());
        pop_compare("reset");
        check("reset.stall", 32'(bus.stall), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].i);
            #1;
            check({vecs[k].name, ".stall"}, 32'(bus.stall), 32'd0);
            sb.push_back(vecs[k].e);
            step();
            pop_compare(vecs[k].name);
        end

        // Multiply, then two back-to-back multiplies.
        run_mul("mul_a", 32'h00010001, 32'h00030003, 32'h00060003);
        run_mul("mul_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_mul("mul_sh", 32'h0000FFFF, 32'h00010000, 32'hFFFF0000);

        // Flush in MUL cycle 10 aborts the multiply.
        m = mk_in(3'b010, 32'h5, 32'h7, 32'h18, 0, 1, 5'd1, 5'd7, 32'h40, 0, 4'b1000, 0, 32'h0);
        drive(m);
        repeat (10) step();
        flush = 1'b1;
        drive(nop_in());
        #1;
        check("flush_mul.stall_before", 32'(bus.stall), 32'd1);
        sb.push_back(bubble());
        step();
        flush = 1'b0;
        pop_compare("flush_mul");
        check("flush_mul.stall_after", 32'(bus.stall), 32'd0);

        // Normal op after abort, then flush beats a mul start.
        drive(vecs[0].i);
        sb.push_back(vecs[0].e);
        step();
        pop_compare("post_flush_add");
        drive(m);
        flush = 1'b1;
        #1;
        check("flush_start.stall", 32'(bus.stall), 32'd0);
        sb.push_back(bubble());
        step();
        flush = 1'b0;
        drive(nop_in());
        pop_compare("flush_start");
        #1;
        check("flush_start.stall_after", 32'(bus.stall), 32'd0);

        // Reset in MUL cycle 20 aborts immediately.
        drive(m);
        repeat (20) step();
        rst_n = 1'b0;
        drive(nop_in());
        sb.push_back(bubble());
        step();
        pop_compare("reset_mul");
        check("reset_mul.stall", 32'(bus.stall), 32'd0);
        rst_n = 1'b1;
        drive(vecs[4].i);
        sb.push_back(vecs[4].e);
        step();
        pop_compare("post_reset_lw");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
